// File: rtl/spi_display_receiver.sv
// SPI display receiver: synchronizes an external SPI write stream into clk,
// assembles {dc, byte} words and buffers them in a small FIFO.
module spi_display_receiver #(
    parameter int FIFO_DEPTH   = 4,
    parameter int MIN_SCLK_DIV = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          sclk,
    input  logic                          mosi,
    input  logic                          cs,
    input  logic                          dc,
    output logic [8:0]                    outData,
    output logic                          outValid,
    input  logic                          outReady,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow,
    output logic                          frameErr
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    if (FIFO_DEPTH < 2 || (1 << AW) != FIFO_DEPTH || MIN_SCLK_DIV < 2) begin : gBadParam
        $error("spi_display_receiver: unsupported FIFO_DEPTH or MIN_SCLK_DIV");
    end

    logic [2:0] sclkSync;
    logic [1:0] mosiSync;
    logic [1:0] csSync;
    logic [1:0] dcSync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclkSync <= '0;
            mosiSync <= '0;
            csSync   <= '1;
            dcSync   <= '0;
        end else begin
            sclkSync <= {sclkSync[1:0], sclk};
            mosiSync <= {mosiSync[0], mosi};
            csSync   <= {csSync[0], cs};
            dcSync   <= {dcSync[0], dc};
        end
    end

    logic sclkRise;
    logic mosiS;
    logic csS;
    logic dcS;

    assign sclkRise = sclkSync[1] & ~sclkSync[2];
    assign mosiS    = mosiSync[1];
    assign csS      = csSync[1];
    assign dcS      = dcSync[1];

    logic [0:0] state;
    logic [2:0] bitCnt;
    logic [7:0] shiftReg;
    logic       wrReq;
    logic [8:0] wrData;

    // State mirrors synchronized cs one cycle late, so state/csS disagreeing marks a cs edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            bitCnt   <= '0;
            shiftReg <= '0;
            wrReq    <= 1'b0;
            wrData   <= '0;
            frameErr <= 1'b0;
        end else begin
            wrReq <= 1'b0;
            state <= csS ? IDLE : SHIFT;
            if (state == IDLE && !csS) begin
                bitCnt   <= '0;
                shiftReg <= '0;
            end else if (state == SHIFT && csS) begin
                if (bitCnt != 3'd0) begin
                    bitCnt   <= '0;
                    frameErr <= 1'b1;
                end
            end else if (state == SHIFT && sclkRise) begin
                shiftReg <= {shiftReg[6:0], mosiS};
                bitCnt   <= bitCnt + 3'd1;
                if (bitCnt == 3'd7) begin
                    wrReq  <= 1'b1;
                    wrData <= {dcS, shiftReg[6:0], mosiS};
                end
            end
        end
    end

    logic [8:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wrPtr;
    logic [AW-1:0] rdPtr;
    logic [AW:0]   count;
    logic          full;
    logic          doRead;
    logic          doWrite;

    assign full     = (count == (AW+1)'(FIFO_DEPTH));
    assign outValid = (count != '0);
    assign doRead   = outValid & outReady;
    assign doWrite  = wrReq & (~full | doRead);
    assign level    = count;
    assign outData  = outValid ? mem[rdPtr] : '0;

    always_ff @(posedge clk) begin
        if (doWrite) begin
            mem[wrPtr] <= wrData;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (doWrite) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (doRead) begin
                rdPtr <= rdPtr + 1'b1;
            end
            if (wrReq && full && !doRead) begin
                overflow <= 1'b1;
            end
            case ({doWrite, doRead})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_display_receiver.sv
// Self-checking bench for spi_display_receiver: SPI master driven from the bench,
// expected FIFO contents and flags kept in a transaction-level queue model.
module tb_spi_display_receiver;

    localparam int DEPTH = 4;
    localparam int MINDIV = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       sclk;
    logic       mosi;
    logic       cs;
    logic       dc;
    logic [8:0] outData;
    logic       outValid;
    logic       outReady;
    logic [2:0] level;
    logic       overflow;
    logic       frameErr;

    int compared = 0;
    int mismatched = 0;

    logic [8:0] modelQ[$];
    logic       modelOvf;
    logic       modelFerr;

    spi_display_receiver #(.FIFO_DEPTH(DEPTH), .MIN_SCLK_DIV(MINDIV)) dut (
        .clk(clk), .reset(reset), .sclk(sclk), .mosi(mosi), .cs(cs), .dc(dc),
        .outData(outData), .outValid(outValid), .outReady(outReady),
        .level(level), .overflow(overflow), .frameErr(frameErr)
    );

    always #5 clk = ~clk;

    task automatic doReset();
        @(negedge clk);
        reset = 1'b1; sclk = 1'b0; mosi = 1'b0; cs = 1'b1; dc = 1'b0; outReady = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        modelQ.delete();
        modelOvf = 1'b0;
        modelFerr = 1'b0;
    endtask

    task automatic modelPush(input logic [8:0] v);
        if (modelQ.size() < DEPTH) modelQ.push_back(v);
        else modelOvf = 1'b1;
    endtask

    // Sends the top n bits of b MSB first; mosi changes while sclk is low.
    // rdOnLast pulses outReady so the read lands on the same edge as the byte's FIFO write.
    task automatic sendBits(input logic [7:0] b, input int n, input int div, input logic rdOnLast);
        for (int i = 0; i < n; i++) begin
            mosi = b[7-i];
            repeat (div) @(negedge clk);
            sclk = 1'b1;
            if (rdOnLast && i == n - 1) begin
                repeat (3) @(negedge clk);
                outReady = 1'b1;
                @(negedge clk);
                outReady = 1'b0;
                repeat (div - 4) @(negedge clk);
            end else begin
                repeat (div) @(negedge clk);
            end
            sclk = 1'b0;
        end
    endtask

    task automatic csLow();
        cs = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic csHigh();
        repeat (4) @(negedge clk);
        cs = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic sendFrame(input logic [8:0] bytes[$], input int div);
        csLow();
        for (int i = 0; i < bytes.size(); i++) begin
            dc = bytes[i][8];
            sendBits(bytes[i][7:0], 8, div, 1'b0);
            modelPush(bytes[i]);
        end
        csHigh();
    endtask

    task automatic drain(output logic [8:0] got[$]);
        got = {};
        for (int k = 0; k < 4 * DEPTH; k++) begin
            @(negedge clk);
            if (!outValid) break;
            got.push_back(outData);
            outReady = 1'b1;
            @(negedge clk);
            outReady = 1'b0;
        end
    endtask

    task automatic test_reset();
        doReset();
        compared++; if (outValid !== 1'b0) begin mismatched++; $display("FAIL reset.outValid got %0b want 0", outValid); end
        compared++; if (outData !== 9'h000) begin mismatched++; $display("FAIL reset.outData got %h want 000", outData); end
        compared++; if (level !== 3'd0) begin mismatched++; $display("FAIL reset.level got %0d want 0", level); end
        compared++; if (overflow !== 1'b0) begin mismatched++; $display("FAIL reset.overflow got %0b want 0", overflow); end
        compared++; if (frameErr !== 1'b0) begin mismatched++; $display("FAIL reset.frameErr got %0b want 0", frameErr); end
    endtask

    task automatic test_single();
        logic [8:0] q[$];
        logic [8:0] got[$];
        doReset();
        q = {9'h0AE};
        sendFrame(q, 8);
        compared++; if (outValid !== 1'b1) begin mismatched++; $display("FAIL single.outValid got %0b want 1", outValid); end
        compared++; if (outData !== 9'h0AE) begin mismatched++; $display("FAIL single.outData got %h want 0ae", outData); end
        compared++; if (level !== 3'd1) begin mismatched++; $display("FAIL single.level got %0d want 1", level); end
        compared++; if ({overflow, frameErr} !== 2'b00) begin mismatched++; $display("FAIL single.flags got %b want 00", {overflow, frameErr}); end
        drain(got);
        compared++; if (got.size() !== 1) begin mismatched++; $display("FAIL single.count got %0d want 1", got.size()); end
    endtask

    task automatic test_back_to_back();
        logic [8:0] got[$];
        logic [8:0] exp[$];
        doReset();
        outReady = 1'b1;
        exp = {9'h112, 9'h134, 9'h156};
        got = {};
        fork
            sendFrame(exp, 8);
            for (int k = 0; k < 600; k++) begin
                @(negedge clk);
                if (outValid) got.push_back(outData);
            end
        join
        outReady = 1'b0;
        compared++; if (got.size() !== 3) begin mismatched++; $display("FAIL b2b.count got %0d want 3", got.size()); end
        foreach (got[k]) if (k < 3) begin
            compared++; if (got[k] !== exp[k]) begin mismatched++; $display("FAIL b2b.data[%0d] got %h want %h", k, got[k], exp[k]); end
        end
        compared++; if (level !== 3'd0) begin mismatched++; $display("FAIL b2b.level got %0d want 0", level); end
        modelQ.delete();
    endtask

    task automatic test_overflow();
        logic [8:0] q[$];
        logic [8:0] got[$];
        doReset();
        q = {};
        for (int i = 0; i < 5; i++) q.push_back(9'($urandom));
        sendFrame(q, 6);
        compared++; if (level !== 3'd4) begin mismatched++; $display("FAIL ovf.level got %0d want 4", level); end
        compared++; if (overflow !== modelOvf) begin mismatched++; $display("FAIL ovf.overflow got %0b want %0b", overflow, modelOvf); end
        compared++; if (outData !== q[0]) begin mismatched++; $display("FAIL ovf.head got %h want %h", outData, q[0]); end
        drain(got);
        compared++; if (got.size() !== modelQ.size()) begin mismatched++; $display("FAIL ovf.count got %0d want %0d", got.size(), modelQ.size()); end
        foreach (got[k]) if (k < modelQ.size()) begin
            compared++; if (got[k] !== modelQ[k]) begin mismatched++; $display("FAIL ovf.data[%0d] got %h want %h", k, got[k], modelQ[k]); end
        end
        compared++; if (overflow !== 1'b1) begin mismatched++; $display("FAIL ovf.sticky got %0b want 1", overflow); end
    endtask

    task automatic test_full_rw();
        logic [8:0] got[$];
        logic [8:0] v;
        doReset();
        csLow();
        for (int i = 0; i < 5; i++) begin
            v = 9'($urandom);
            dc = v[8];
            sendBits(v[7:0], 8, 8, i == 4);
            if (i == 4) void'(modelQ.pop_front());
            modelPush(v);
        end
        csHigh();
        compared++; if (level !== 3'd4) begin mismatched++; $display("FAIL fullrw.level got %0d want 4", level); end
        compared++; if (overflow !== 1'b0) begin mismatched++; $display("FAIL fullrw.overflow got %0b want 0", overflow); end
        drain(got);
        compared++; if (got.size() !== modelQ.size()) begin mismatched++; $display("FAIL fullrw.count got %0d want %0d", got.size(), modelQ.size()); end
        foreach (got[k]) if (k < modelQ.size()) begin
            compared++; if (got[k] !== modelQ[k]) begin mismatched++; $display("FAIL fullrw.data[%0d] got %h want %h", k, got[k], modelQ[k]); end
        end
    endtask

    task automatic test_frame_err();
        logic [8:0] q[$];
        logic [8:0] got[$];
        doReset();
        csLow();
        dc = 1'b0;
        sendBits(8'($urandom), 5, 6, 1'b0);
        csHigh();
        modelFerr = 1'b1;
        compared++; if (frameErr !== modelFerr) begin mismatched++; $display("FAIL ferr.flag got %0b want 1", frameErr); end
        compared++; if (level !== 3'd0) begin mismatched++; $display("FAIL ferr.partial level got %0d want 0", level); end
        q = {9'h1FF};
        sendFrame(q, 6);
        compared++; if (frameErr !== 1'b1) begin mismatched++; $display("FAIL ferr.sticky got %0b want 1", frameErr); end
        compared++; if (level !== 3'd1) begin mismatched++; $display("FAIL ferr.level got %0d want 1", level); end
        drain(got);
        compared++; if (got.size() !== 1 || got[0] !== 9'h1FF) begin mismatched++; $display("FAIL ferr.data got %0d entries head %h want 1 entry 1ff", got.size(), got.size() > 0 ? got[0] : 9'h000); end
    endtask

    task automatic test_reset_midbyte();
        logic [8:0] q[$];
        logic [8:0] got[$];
        doReset();
        q = {9'h133};
        sendFrame(q, 4);
        csLow();
        dc = 1'b0;
        sendBits(8'($urandom), 3, 6, 1'b0);
        reset = 1'b1;
        #1;
        compared++; if (level !== 3'd0 || outValid !== 1'b0) begin mismatched++; $display("FAIL rstmid.async level %0d valid %0b want 0 0", level, outValid); end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        modelQ.delete();
        csHigh();
        compared++; if (frameErr !== 1'b0) begin mismatched++; $display("FAIL rstmid.frameErr got %0b want 0", frameErr); end
        q = {9'h0A5};
        sendFrame(q, 8);
        compared++; if (frameErr !== 1'b0) begin mismatched++; $display("FAIL rstmid.frameErr2 got %0b want 0", frameErr); end
        compared++; if (outData !== 9'h0A5) begin mismatched++; $display("FAIL rstmid.outData got %h want 0a5", outData); end
        compared++; if (level !== 3'd1) begin mismatched++; $display("FAIL rstmid.level got %0d want 1", level); end
        drain(got);
    endtask

    task automatic test_idle_sclk();
        doReset();
        for (int i = 0; i < 40; i++) begin
            mosi = 1'($urandom);
            dc = 1'($urandom);
            sclk = ~sclk;
            repeat ($urandom_range(8, MINDIV)) @(negedge clk);
        end
        sclk = 1'b0;
        repeat (6) @(negedge clk);
        compared++; if (level !== 3'd0) begin mismatched++; $display("FAIL idle.level got %0d want 0", level); end
        compared++; if ({overflow, frameErr} !== 2'b00) begin mismatched++; $display("FAIL idle.flags got %b want 00", {overflow, frameErr}); end
    endtask

    task automatic test_random();
        logic [8:0] q[$];
        logic [8:0] got[$];
        int n;
        int div;
        doReset();
        for (int r = 0; r < 8; r++) begin
            n = $urandom_range(6, 1);
            div = $urandom_range(8, MINDIV);
            q = {};
            for (int i = 0; i < n; i++) q.push_back(9'($urandom));
            sendFrame(q, div);
            compared++; if (level !== 3'(modelQ.size())) begin mismatched++; $display("FAIL rand[%0d].level got %0d want %0d", r, level, modelQ.size()); end
            compared++; if (overflow !== modelOvf) begin mismatched++; $display("FAIL rand[%0d].overflow got %0b want %0b", r, overflow, modelOvf); end
            compared++; if (frameErr !== 1'b0) begin mismatched++; $display("FAIL rand[%0d].frameErr got %0b want 0", r, frameErr); end
            drain(got);
            compared++; if (got.size() !== modelQ.size()) begin mismatched++; $display("FAIL rand[%0d].count got %0d want %0d", r, got.size(), modelQ.size()); end
            foreach (got[k]) if (k < modelQ.size()) begin
                compared++; if (got[k] !== modelQ[k]) begin mismatched++; $display("FAIL rand[%0d].data[%0d] got %h want %h", r, k, got[k], modelQ[k]); end
            end
            modelQ.delete();
        end
    endtask

    initial begin
        reset = 1'b1; sclk = 1'b0; mosi = 1'b0; cs = 1'b1; dc = 1'b0; outReady = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_full_rw();
        test_frame_err();
        test_reset_midbyte();
        test_idle_sclk();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/spi_display_receiver.md
SPI_DISPLAY_RECEIVER -- requirements
Module: spi_display_receiver

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, number of buffered received bytes (power of two, >=2).
REQ-002 SHALL have parameter MIN_SCLK_DIV, default 4, minimum clk cycles per sclk half-period supported.
REQ-003 clk  input  1  sole system clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 sclk  input  1  serial clock from display master, asynchronous to clk.
REQ-006 mosi  input  1  serial data, MSB first, changes on sclk falling edge.
REQ-007 cs  input  1  chip select, active-low.
REQ-008 dc  input  1  data/command select: 0 = command, 1 = data.
REQ-009 outData  output  9  FIFO head: {dc, byte[7:0]}.
REQ-010 outValid  output  1  FIFO non-empty.
REQ-011 outReady  input  1  consumer accepts head when outValid & outReady.
REQ-012 level  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-013 overflow  output  1  sticky: completed byte dropped because FIFO full.
REQ-014 frameErr  output  1  sticky: cs deasserted mid-byte.

Function
REQ-015 sclk, mosi, cs, dc SHALL each pass a 2-flop synchronizer; a third sclk stage provides edge detection.
REQ-016 sclk rise SHALL be detected when sync stage 2 = 1 and stage 3 = 0; no other sclk event is used.
REQ-017 Receiver SHALL be in state IDLE when synchronized cs = 1 and SHIFT when cs = 0; all sclk edges are ignored in IDLE.
REQ-018 In SHIFT, each detected sclk rise SHALL shift synchronized mosi into an 8-bit register LSB side and increment a 3-bit bit counter.
REQ-019 On the rise that brings bit counter from 7 to 0 (wrap), SHALL latch synchronized dc with the completed byte and issue a single-cycle FIFO write request the next clk cycle.
REQ-020 Latency: FIFO write SHALL occur exactly 1 clk after the 8th detected rise; outValid SHALL rise the cycle after the write when FIFO was empty.
REQ-021 Consecutive bytes without cs deassertion SHALL be received back-to-back; bit counter is not reset between bytes.
REQ-022 cs transition 0->1 with bit counter != 0 SHALL discard the partial byte, clear the bit counter, and set frameErr.
REQ-023 cs transition 0->1 with bit counter = 0 SHALL clear nothing else and raise no error.
REQ-024 cs transition 1->0 SHALL clear the bit counter and shift register.
REQ-025 FIFO read SHALL occur when outValid & outReady; outData presents the next entry the following cycle.
REQ-026 Write while full and no read in same cycle SHALL drop the byte, leave contents unchanged, and set overflow.
REQ-027 Simultaneous write and read while full SHALL accept the write; level unchanged.
REQ-028 Simultaneous write and read while empty SHALL be impossible to pass through: read ignored (outValid = 0), write accepted.
REQ-029 Read and write pointers SHALL wrap modulo FIFO_DEPTH; level SHALL range 0..FIFO_DEPTH.
REQ-030 overflow and frameErr SHALL remain set until reset.
REQ-031 outReady asserted with outValid = 0 SHALL have no effect.

Reset
REQ-032 On reset assertion, immediately: state IDLE, bit counter 0, shift register 0, FIFO empty, level 0, outValid 0, outData 0, overflow 0, frameErr 0, synchronizer flops 1 for cs, 0 otherwise.
REQ-033 Reset asserted mid-byte SHALL discard the partial byte without setting frameErr; reception resumes on the next cs falling edge after release.

Verification
REQ-034 cs=0, dc=0, send 0xAE (sclk div 8), outReady=0 -> outData=0x0AE, outValid=1, level=1, no error flags.
REQ-035 cs=0, dc=1, send 0x12,0x34,0x56 back-to-back, outReady=1 -> three reads 0x112,0x134,0x156 in order, level returns 0.
REQ-036 outReady=0, send 5 bytes with FIFO_DEPTH=4 -> level=4, overflow=1, head=first byte, fifth byte absent.
REQ-037 send 5 bits then cs=1, then full byte 0xFF with dc=1 -> frameErr=1, only 0x1FF queued.
REQ-038 reset pulsed after 3 bits, then full byte 0xA5, dc=0 -> frameErr=0, outData=0x0A5, level=1.
REQ-039 sclk toggling with cs=1 -> level stays 0, no flags set.
